input_conditioner: RTL and testbench

Input-side counterpart of the segment/LED output path: it takes the five raw push buttons and fifteen raw SPDT switches from the board pins and turns them into clean signals for the service blocks and the top-level mode decode. Each input is synchronized and debounced into a stable level. Buttons also produce single-cycle press and release pulses. Buttons selected by a mask (up/down by default) additionally produce auto-repeat events while held. The block sits between the pins and the service blocks, which consume only its outputs.

---
 rtl/input_conditioner_pkg.sv | 27 ++
 rtl/input_conditioner_if.sv | 38 +++
 rtl/input_conditioner_debounce_channel.sv | 57 +++++
 rtl/input_conditioner.sv | 122 ++++++++++++
 tb/tb_input_conditioner.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the input conditioner.
// Channel counts, button indices, default repeat mask, repeat FSM states.

package input_conditioner_pkg;

    localparam int N_PUSH = 5;
    localparam int N_SPDT = 15;

    localparam int PUSH_U = 0;
    localparam int PUSH_D = 1;
    localparam int PUSH_L = 2;
    localparam int PUSH_R = 3;
    localparam int PUSH_M = 4;

    localparam logic [N_PUSH-1:0] REPEAT_MASK_DEF = 5'b00011;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw inputs and clean outputs.
// master: board/driver side. slave: the conditioner itself.

interface input_conditioner_if;
    import input_conditioner_pkg::*;

    logic [N_PUSH-1:0] push_raw;
    logic [N_SPDT-1:0] spdt_raw;
    logic [N_PUSH-1:0] push_level;
    logic [N_PUSH-1:0] push_press;
    logic [N_PUSH-1:0] push_release;
    logic [N_PUSH-1:0] push_evt;
    logic [N_SPDT-1:0] spdt_level;
    logic [N_SPDT-1:0] spdt_toggle;

    modport master (
        output push_raw,
        output spdt_raw,
        input  push_level,
        input  push_press,
        input  push_release,
        input  push_evt,
        input  spdt_level,
        input  spdt_toggle
    );

    modport slave (
        input  push_raw,
        input  spdt_raw,
        output push_level,
        output push_press,
        output push_release,
        output push_evt,
        output spdt_level,
        output spdt_toggle
    );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: 2-flop synchronizer, debounce counter, stable level.
// Ports: clk, resetn, i_raw -> o_level, o_rise/o_fall (1-cycle pulses).

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // The counter only runs while the sample disagrees with the level
    // and is cleared on agreement or on acceptance, so it never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync;
                r_cnt   <= '0;
                r_rise  <= r_sync;
                r_fall  <= ~r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces 5 buttons and 15 switches, adds auto-repeat.
// Ports: clk, resetn, bus (slave): raw inputs in, levels/pulses out.

module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                DEBOUNCE_CYCLES = 4,
    parameter int                REPEAT_DELAY    = 16,
    parameter int                REPEAT_PERIOD   = 4,
    parameter logic [N_PUSH-1:0] REPEAT_MASK     = REPEAT_MASK_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input_conditioner_if.slave  bus
);

    localparam int RW = $clog2(imax(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] DLY_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LOAD = RW'(REPEAT_PERIOD - 1);

    logic [N_PUSH-1:0] w_plevel;
    logic [N_PUSH-1:0] w_press;
    logic [N_PUSH-1:0] w_release;
    logic [N_PUSH-1:0] w_rep;
    logic [N_SPDT-1:0] w_slevel;
    logic [N_SPDT-1:0] w_srise;
    logic [N_SPDT-1:0] w_sfall;

    for (genvar i = 0; i < N_PUSH; i++) begin : g_push
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .resetn  (resetn),
            .i_raw   (bus.push_raw[i]),
            .o_level (w_plevel[i]),
            .o_rise  (w_press[i]),
            .o_fall  (w_release[i])
        );
    end

    for (genvar i = 0; i < N_SPDT; i++) begin : g_spdt
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .resetn  (resetn),
            .i_raw   (bus.spdt_raw[i]),
            .o_level (w_slevel[i]),
            .o_rise  (w_srise[i]),
            .o_fall  (w_sfall[i])
        );
    end

    // Repeat pulse is decoded from registered state in the cycle the
    // counter reaches zero, so the first repeat lands exactly
    // REPEAT_DELAY cycles after the press pulse.
    for (genvar i = 0; i < N_PUSH; i++) begin : g_rpt
        if (REPEAT_MASK[i]) begin : g_on
            rpt_state_t    r_state;
            rpt_state_t    w_state_nxt;
            logic [RW-1:0] r_rcnt;
            logic [RW-1:0] w_rcnt_nxt;
            logic          w_fire;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_state <= RPT_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_rcnt  <= w_rcnt_nxt;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_rcnt_nxt  = r_rcnt;
                w_fire      = 1'b0;
                if (w_release[i]) begin
                    // release wins over a repeat due this cycle
                    w_state_nxt = RPT_IDLE;
                    w_rcnt_nxt  = '0;
                end else begin
                    unique case (r_state)
                        RPT_IDLE: begin
                            if (w_press[i]) begin
                                w_state_nxt = RPT_DELAY;
                                w_rcnt_nxt  = DLY_LOAD;
                            end
                        end
                        RPT_DELAY, RPT_REPEAT: begin
                            if (r_rcnt == '0) begin
                                w_fire      = 1'b1;
                                w_state_nxt = RPT_REPEAT;
                                w_rcnt_nxt  = PER_LOAD;
                            end else begin
                                w_rcnt_nxt = r_rcnt - 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = RPT_IDLE;
                            w_rcnt_nxt  = '0;
                        end
                    endcase
                end
            end

            assign w_rep[i] = w_fire;
        end else begin : g_off
            assign w_rep[i] = 1'b0;
        end
    end

    assign bus.push_level   = w_plevel;
    assign bus.push_press   = w_press;
    assign bus.push_release = w_release;
    assign bus.push_evt     = w_press | w_rep;
    assign bus.spdt_level   = w_slevel;
    assign bus.spdt_toggle  = w_srise | w_sfall;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: vector table plus
// hand-written multi-cycle sequences (bounce, repeat, race, reset).

module tb_input_conditioner;
    import input_conditioner_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    input_conditioner_if bus();

    input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (16),
        .REPEAT_PERIOD   (4),
        .REPEAT_MASK     (5'b00011)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  push;
        logic [14:0] spdt;
        int          n;
        logic [4:0]  lvl;
        logic [4:0]  prs;
        logic [4:0]  rel;
        logic [4:0]  evt;
        logic [14:0] slv;
        logic [14:0] tgl;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lvl"}, 32'(bus.push_level), 0);
        chk({tag, "_prs"}, 32'(bus.push_press), 0);
        chk({tag, "_rel"}, 32'(bus.push_release), 0);
        chk({tag, "_evt"}, 32'(bus.push_evt), 0);
        chk({tag, "_slv"}, 32'(bus.spdt_level), 0);
        chk({tag, "_tgl"}, 32'(bus.spdt_toggle), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int found;
        int toggles;
        int rise_j;
        int j;

        vt[0] = '{5'b00000, 15'h0000, 1, 5'b00000, 5'b00000,
                  5'b00000, 5'b00000, 15'h0000, 15'h0000};
        vt[1] = '{5'b10000, 15'h0000, 5, 5'b00000, 5'b00000,
                  5'b00000, 5'b00000, 15'h0000, 15'h0000};
        vt[2] = '{5'b10000, 15'h0000, 1, 5'b10000, 5'b10000,
                  5'b00000, 5'b10000, 15'h0000, 15'h0000};
        vt[3] = '{5'b10000, 15'h0000, 1, 5'b10000, 5'b00000,
                  5'b00000, 5'b00000, 15'h0000, 15'h0000};
        vt[4] = '{5'b10100, 15'h0001, 6, 5'b10100, 5'b00100,
                  5'b00000, 5'b00100, 15'h0001, 15'h0001};
        vt[5] = '{5'b00100, 15'h0001, 6, 5'b00100, 5'b00000,
                  5'b10000, 5'b00000, 15'h0001, 15'h0000};
        vt[6] = '{5'b00000, 15'h4001, 3, 5'b00100, 5'b00000,
                  5'b00000, 5'b00000, 15'h0001, 15'h0000};
        vt[7] = '{5'b00000, 15'h4001, 3, 5'b00000, 5'b00000,
                  5'b00100, 5'b00000, 15'h4001, 15'h4000};
        vt[8] = '{5'b00000, 15'h0000, 6, 5'b00000, 5'b00000,
                  5'b00000, 5'b00000, 15'h0000, 15'h4001};

        bus.push_raw = '0;
        bus.spdt_raw = '0;
        resetn = 1'b0;
        tick(2);
        chk_zero("in_reset");
        resetn = 1'b1;
        tick(1);
        chk_zero("post_reset");

        for (int i = 0; i < 9; i++) begin
            bus.push_raw = vt[i].push;
            bus.spdt_raw = vt[i].spdt;
            tick(vt[i].n);
            chk($sformatf("v%0d_lvl", i), 32'(bus.push_level), 32'(vt[i].lvl));
            chk($sformatf("v%0d_prs", i), 32'(bus.push_press), 32'(vt[i].prs));
            chk($sformatf("v%0d_rel", i), 32'(bus.push_release), 32'(vt[i].rel));
            chk($sformatf("v%0d_evt", i), 32'(bus.push_evt), 32'(vt[i].evt));
            chk($sformatf("v%0d_slv", i), 32'(bus.spdt_level), 32'(vt[i].slv));
            chk($sformatf("v%0d_tgl", i), 32'(bus.spdt_toggle), 32'(vt[i].tgl));
        end

        // bounce on spdt[11]: 1,0,1,0 every 2 cycles, then hold 1
        toggles = 0;
        rise_j = -1;
        for (int k = 0; k < 4; k++) begin
            bus.spdt_raw[11] = (k % 2 == 0);
            for (int m = 0; m < 2; m++) begin
                tick(1);
                if (bus.spdt_toggle[11]) toggles++;
                if (bus.spdt_level[11] && rise_j < 0) rise_j = 0;
            end
        end
        bus.spdt_raw[11] = 1'b1;
        for (int m = 1; m <= 12; m++) begin
            tick(1);
            if (bus.spdt_toggle[11]) toggles++;
            if (bus.spdt_level[11] && rise_j < 0) rise_j = m;
        end
        chk("bounce_toggles", toggles, 1);
        chk("bounce_rise_lat", rise_j, 6);
        bus.spdt_raw[11] = 1'b0;
        tick(10);

        // auto-repeat on up
        bus.push_raw[PUSH_U] = 1'b1;
        found = 0;
        for (int m = 0; m < 12; m++) begin
            tick(1);
            if (bus.push_press[PUSH_U]) begin
                found = 1;
                break;
            end
        end
        chk("rpt_press_seen", found, 1);
        chk("rpt_evt_p0", 32'(bus.push_evt[PUSH_U]), 1);
        for (int off = 1; off < 40; off++) begin
            tick(1);
            chk($sformatf("rpt_evt_p%0d", off), 32'(bus.push_evt[PUSH_U]),
                32'((off >= 16 && (off - 16) % 4 == 0) ? 1 : 0));
        end
        bus.push_raw[PUSH_U] = 1'b0;
        found = 0;
        for (int m = 0; m < 12; m++) begin
            tick(1);
            if (bus.push_release[PUSH_U]) begin
                found = 1;
                break;
            end
        end
        chk("rpt_release_seen", found, 1);
        toggles = 0;
        for (int m = 0; m < 24; m++) begin
            tick(1);
            if (bus.push_evt[PUSH_U]) toggles++;
        end
        chk("rpt_after_release", toggles, 0);

        // release landing on a due repeat on down
        bus.push_raw[PUSH_D] = 1'b1;
        found = 0;
        for (int m = 0; m < 12; m++) begin
            tick(1);
            if (bus.push_press[PUSH_D]) begin
                found = 1;
                break;
            end
        end
        chk("race_press_seen", found, 1);
        for (int off = 1; off <= 24; off++) begin
            tick(1);
            if (off == 16)
                chk("race_rep16", 32'(bus.push_evt[PUSH_D]), 1);
            if (off == 20) begin
                chk("race_rel20", 32'(bus.push_release[PUSH_D]), 1);
                chk("race_evt20", 32'(bus.push_evt[PUSH_D]), 0);
            end
            if (off == 24)
                chk("race_evt24", 32'(bus.push_evt[PUSH_D]), 0);
            if (off == 14) bus.push_raw[PUSH_D] = 1'b0;
        end
        tick(10);

        // simultaneous rise on up, right and spdt[14]
        bus.push_raw[PUSH_U] = 1'b1;
        bus.push_raw[PUSH_R] = 1'b1;
        bus.spdt_raw[14] = 1'b1;
        j = -1;
        for (int m = 1; m <= 12; m++) begin
            tick(1);
            if (bus.push_press[PUSH_U] | bus.push_press[PUSH_R] |
                bus.spdt_toggle[14]) begin
                j = m;
                break;
            end
        end
        chk("sim_lat", j, 6);
        chk("sim_press_u", 32'(bus.push_press[PUSH_U]), 1);
        chk("sim_press_r", 32'(bus.push_press[PUSH_R]), 1);
        chk("sim_tgl_14", 32'(bus.spdt_toggle[14]), 1);
        bus.push_raw = '0;
        bus.spdt_raw = '0;
        tick(12);

        // reset mid-debounce with spdt[13] held high
        bus.spdt_raw[13] = 1'b1;
        tick(3);
        resetn = 1'b0;
        #1;
        chk_zero("rst_async");
        tick(2);
        chk_zero("rst_held");
        resetn = 1'b1;
        rise_j = -1;
        for (int m = 1; m <= 10; m++) begin
            tick(1);
            if (m == 1) chk_zero("rst_first");
            if (bus.spdt_level[13] && rise_j < 0) begin
                rise_j = m;
                chk("rst_tgl_at_rise", 32'(bus.spdt_toggle[13]), 1);
            end
        end
        chk("rst_rise_lat", rise_j, 6);
        chk("rst_tgl_end", 32'(bus.spdt_toggle[13]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
